// File: rtl/mini_alu_seq_if.sv
// Instruction-issue and result bus of the mini_alu_seq execution unit.
// The master side issues instructions; the slave side is the ALU.
interface mini_alu_seq_if #(
    parameter int ADDR_W = 8
);
    logic              iInstrValid;
    logic              oInstrReady;
    logic [3:0]        iOpcode;
    logic [ADDR_W-1:0] iDest;
    logic [ADDR_W-1:0] iSrc1;
    logic [ADDR_W-1:0] iSrc0;
    logic              oBranchTaken;
    logic [ADDR_W-1:0] oBranchTarget;
    logic [7:0]        oLed;
    logic              oVgaWrite;
    logic [15:0]       oVgaAddr;
    logic [2:0]        oVgaColor;
    logic              oZero;
    logic              oCarry;
    logic              oIllegal;

    modport master (
        output iInstrValid, iOpcode, iDest, iSrc1, iSrc0,
        input  oInstrReady, oBranchTaken, oBranchTarget, oLed,
               oVgaWrite, oVgaAddr, oVgaColor, oZero, oCarry, oIllegal
    );

    modport slave (
        input  iInstrValid, iOpcode, iDest, iSrc1, iSrc0,
        output oInstrReady, oBranchTaken, oBranchTarget, oLed,
               oVgaWrite, oVgaAddr, oVgaColor, oZero, oCarry, oIllegal
    );
endinterface

// File: rtl/mini_alu_seq.sv
// Small register-file ALU: single-cycle arithmetic/branch/IO ops plus a
// shift-add multiplier (signed and unsigned) that stalls issue while it runs.
module mini_alu_seq #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    mini_alu_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_STO  = 4'd2,
        OP_BLE  = 4'd3,
        OP_JMP  = 4'd4,
        OP_LED  = 4'd5,
        OP_SUB  = 4'd6,
        OP_SMUL = 4'd7,
        OP_UMUL = 4'd8,
        OP_VGA  = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WB_HI = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [2*WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;

    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic [7:0]          led_q, led_d;
    logic                branch_q, branch_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                vga_we_q, vga_we_d;
    logic [15:0]         vga_addr_q, vga_addr_d;
    logic [2:0]          vga_color_q, vga_color_d;
    logic                illegal_q, illegal_d;

    logic [WIDTH-1:0]    rf_q [2**ADDR_W];
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [WIDTH-1:0]    rf_wdata;

    logic                ready;
    logic                accept;
    logic [WIDTH-1:0]    src1_val, src0_val;
    logic [2:0]          dest_color;
    logic [WIDTH:0]      sum, diff;
    logic [2*ADDR_W-1:0] imm;
    logic [2*WIDTH-1:0]  partial;
    logic [WIDTH-1:0]    prod_hi;
    logic [ADDR_W-1:0]   dest_hi;

    // R[0] is hard-wired to zero on every read port; its storage is never written.
    assign src1_val   = (bus.iSrc1 == '0) ? '0 : rf_q[bus.iSrc1];
    assign src0_val   = (bus.iSrc0 == '0) ? '0 : rf_q[bus.iSrc0];
    assign dest_color = (bus.iDest == '0) ? '0 : rf_q[bus.iDest][2:0];

    assign ready   = (state_q == IDLE) && !Reset;
    assign accept  = bus.iInstrValid && ready;
    assign sum     = {1'b0, src1_val} + {1'b0, src0_val};
    assign diff    = {1'b0, src1_val} - {1'b0, src0_val};
    assign imm     = {bus.iSrc1, bus.iSrc0};
    assign partial = mplier_q[0] ? mcand_q : '0;
    assign prod_hi = acc_q[2*WIDTH-1:WIDTH];
    assign dest_hi = dest_q + ADDR_W'(1);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        signed_d    = signed_q;
        dest_d      = dest_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        led_d       = led_q;
        branch_d    = 1'b0;
        target_d    = target_q;
        vga_we_d    = 1'b0;
        vga_addr_d  = vga_addr_q;
        vga_color_d = vga_color_q;
        illegal_d   = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = bus.iDest;
        rf_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.iOpcode)
                        OP_NOP: ;
                        OP_ADD: begin
                            rf_we    = 1'b1;
                            rf_wdata = sum[WIDTH-1:0];
                            carry_d  = sum[WIDTH];
                            zero_d   = (sum[WIDTH-1:0] == '0);
                        end
                        OP_SUB: begin
                            rf_we    = 1'b1;
                            rf_wdata = diff[WIDTH-1:0];
                            carry_d  = diff[WIDTH];
                            zero_d   = (diff[WIDTH-1:0] == '0);
                        end
                        OP_STO: begin
                            rf_we    = 1'b1;
                            rf_wdata = WIDTH'(imm);
                        end
                        OP_BLE: begin
                            if (src1_val <= src0_val) begin
                                branch_d = 1'b1;
                                target_d = bus.iDest;
                            end
                        end
                        OP_JMP: begin
                            branch_d = 1'b1;
                            target_d = bus.iDest;
                        end
                        OP_LED: led_d = src1_val[7:0];
                        OP_VGA: begin
                            vga_we_d    = 1'b1;
                            vga_addr_d  = {src1_val[7:0], src0_val[7:0]};
                            vga_color_d = dest_color;
                        end
                        OP_SMUL, OP_UMUL: begin
                            state_d  = MUL;
                            signed_d = (bus.iOpcode == OP_SMUL);
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{signed_d & src1_val[WIDTH-1]}}, src1_val};
                            mplier_d = src0_val;
                            cnt_d    = '0;
                            dest_d   = bus.iDest;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            MUL: begin
                // The multiplier's MSB carries negative weight in a signed multiply.
                if (signed_q && cnt_q == CNT_LAST) acc_d = acc_q - partial;
                else                               acc_d = acc_q + partial;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = WB_HI;
                    rf_we    = 1'b1;
                    rf_waddr = dest_q;
                    rf_wdata = acc_d[WIDTH-1:0];
                end
            end
            WB_HI: begin
                state_d  = IDLE;
                rf_we    = 1'b1;
                rf_waddr = dest_hi;
                rf_wdata = prod_hi;
                zero_d   = (acc_q == '0);
                carry_d  = signed_q ? (prod_hi != {WIDTH{acc_q[WIDTH-1]}})
                                    : (prod_hi != '0);
            end
            default: state_d = IDLE;
        endcase

        if (rf_waddr == '0) rf_we = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            signed_q    <= 1'b0;
            dest_q      <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            led_q       <= '0;
            branch_q    <= 1'b0;
            target_q    <= '0;
            vga_we_q    <= 1'b0;
            vga_addr_q  <= '0;
            vga_color_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            signed_q    <= signed_d;
            dest_q      <= dest_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            led_q       <= led_d;
            branch_q    <= branch_d;
            target_q    <= target_d;
            vga_we_q    <= vga_we_d;
            vga_addr_q  <= vga_addr_d;
            vga_color_q <= vga_color_d;
            illegal_q   <= illegal_d;
        end
    end

    // NOTE: the register file is deliberately not reset; reset only blocks writes,
    // which is also what aborts an in-flight multiply cleanly.
    always_ff @(posedge Clock) begin
        if (rf_we && !Reset) rf_q[rf_waddr] <= rf_wdata;
    end

    assign bus.oInstrReady   = ready;
    assign bus.oBranchTaken  = branch_q;
    assign bus.oBranchTarget = target_q;
    assign bus.oLed          = led_q;
    assign bus.oVgaWrite     = vga_we_q;
    assign bus.oVgaAddr      = vga_addr_q;
    assign bus.oVgaColor     = vga_color_q;
    assign bus.oZero         = zero_q;
    assign bus.oCarry        = carry_q;
    assign bus.oIllegal      = illegal_q;
endmodule

// File: doc/mini_alu_seq.md
MINI_ALU_SEQ -- requirements
Module: mini_alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: data/register width, SHALL be >= 8.
REQ-002 Parameter ADDR_W, default 8: register address width; register file depth SHALL be 2**ADDR_W.
REQ-003 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 iInstrValid  input  1  instruction fields are valid.
REQ-006 oInstrReady  output  1  unit accepts an instruction this cycle.
REQ-007 iOpcode  input  4  operation code.
REQ-008 iDest, iSrc1, iSrc0  input  ADDR_W each  destination / source register addresses, or immediate/target fields.
REQ-009 oBranchTaken  output  1  one-cycle branch pulse.
REQ-010 oBranchTarget  output  ADDR_W  branch target address.
REQ-011 oLed  output  8  LED register.
REQ-012 oVgaWrite  output  1  one-cycle video-memory write strobe.
REQ-013 oVgaAddr  output  16  video write address.
REQ-014 oVgaColor  output  3  RGB write data.
REQ-015 oZero, oCarry  output  1 each  status flags.
REQ-016 oIllegal  output  1  one-cycle unknown-opcode pulse.

Function
REQ-017 An instruction SHALL be accepted on a rising edge where iInstrValid=1 and oInstrReady=1; iInstrValid while ready=0 SHALL be ignored, with no state change.
REQ-018 Register file: R[0] SHALL always read 0, and writes to address 0 SHALL be discarded; reads SHALL be combinational; one write port.
REQ-019 Opcodes: 0 NOP, 1 ADD, 2 STO, 3 BLE, 4 JMP, 5 LED, 6 SUB, 7 SMUL, 8 UMUL, 9 VGA; 10-15 SHALL act as NOP and pulse oIllegal the cycle after acceptance.
REQ-020 Single-cycle ops SHALL write their result on the accepting edge, and oInstrReady SHALL stay 1, giving back-to-back issue with no read-after-write hazard.
REQ-021 ADD: R[Dest] <= R[Src1]+R[Src0] mod 2**WIDTH; oCarry = carry-out; oZero = (truncated result==0).
REQ-022 SUB: R[Dest] <= R[Src1]-R[Src0] mod 2**WIDTH; oCarry = borrow (R[Src1]<R[Src0] unsigned); oZero as in REQ-021.
REQ-023 STO: R[Dest] <= {iSrc1,iSrc0}, zero-extended or truncated to WIDTH; flags unchanged.
REQ-024 BLE: if R[Src1] <= R[Src0] (unsigned), oBranchTaken=1 and oBranchTarget=iDest for exactly the cycle after acceptance; JMP SHALL do the same unconditionally.
REQ-025 LED: oLed <= R[Src1][7:0]; oLed SHALL hold until the next LED.
REQ-026 VGA: for the cycle after acceptance, oVgaWrite=1, oVgaAddr={R[Src1][7:0],R[Src0][7:0]}, oVgaColor=R[Dest][2:0]; no register write.
REQ-027 UMUL/SMUL SHALL be sequential, with FSM states IDLE -> MUL (WIDTH cycles) -> WB_HI -> IDLE.
REQ-028 The multiplier SHALL capture operands at acceptance; oInstrReady SHALL be 0 for exactly WIDTH+1 cycles after the accepting edge.
REQ-029 The multiplier SHALL write the low WIDTH bits to R[Dest] on leaving MUL and the high WIDTH bits to R[(Dest+1) mod 2**ADDR_W] in WB_HI.
REQ-030 The multiplier SHALL set oZero = (full 2*WIDTH product == 0) in WB_HI.
REQ-031 The multiplier SHALL set oCarry in WB_HI: for UMUL, high half != 0; for SMUL, high half != sign-extension of the low half.
REQ-032 SMUL product SHALL equal the exact two's-complement product; UMUL the exact unsigned product.
REQ-033 The R[0] discard rule SHALL also apply to both multiplier writebacks.
REQ-034 Flags SHALL change only on ADD, SUB, UMUL and SMUL.
REQ-035 oBranchTaken, oVgaWrite and oIllegal SHALL be registered single-cycle pulses, never asserted two consecutive cycles by one instruction.

Reset
REQ-036 While Reset=1: FSM=IDLE, oInstrReady=0, oLed=0, oZero=0, oCarry=0, and all pulses, oBranchTarget, oVgaAddr and oVgaColor = 0.
REQ-037 oInstrReady SHALL be 1 in the first cycle after Reset deasserts.
REQ-038 Reset during MUL or WB_HI SHALL abort the multiply with no further register writes.
REQ-039 Register file contents (other than R[0]) SHALL NOT be reset.
REQ-040 Reset SHALL override a simultaneous accept.

Verification
REQ-041 STO R1=0x0005, STO R2=0x0003, ADD R3=R1+R2, back-to-back -> R3=0x0008, oZero=0, oCarry=0, oInstrReady high throughout.
REQ-042 STO R1=0xFFFF, STO R2=0x0001, ADD R3; then SUB R4=R2-R1 -> R3=0x0000, oZero=1, oCarry=1; then R4=0x0002, oCarry=1.
REQ-043 WIDTH=16, R1=0xFFFE (-2), R2=0x0003, SMUL Dest=5 -> ready low exactly 17 cycles, R5=0xFFFA, R6=0xFFFF, oCarry=0; UMUL on the same operands -> R5=0xFFFA, R6=0x0002, oCarry=1.
REQ-044 BLE with R1=3 <= R2=7, iDest=0x40 -> single oBranchTaken pulse with target 0x40; swapped operands -> no pulse; opcode 12 -> one oIllegal pulse and no state change.
REQ-045 UMUL issued, Reset asserted at MUL cycle 5 -> no write to Dest or Dest+1, ready=1 the cycle after reset release; UMUL with Dest=2**ADDR_W-1 -> high half to R[0] discarded, R[0] still reads 0.
REQ-046 VGA with R1=0x0012, R2=0x0034, R3=0x0005 (Src1=1, Src0=2, Dest=3) -> one oVgaWrite pulse, oVgaAddr=0x1234, oVgaColor=3'b101; LED Src1=1 -> oLed=0x12.
